uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, 1 stop bit, LSB first) feeding a first-word-fall-through FIFO.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int DIV   = 16,
  parameter int DEPTH = 8
) (
  input  logic       cpu_clock,
  input  logic       cpu_rst,
  input  logic       rx_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  input  logic       clr,
  output logic       frame_err,
  output logic       overflow,
  output logic       parity_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] HALF_M1  = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_M1  = 16'(DIV - 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  // Two-stage synchronizer; both stages idle high out of reset.
  logic [1:0] sync_reg;
  logic       rxs;
  logic       rxs_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge cpu_clock or posedge cpu_rst) begin
          if (cpu_rst) sync_reg[gi] <= 1'b1;
          else         sync_reg[gi] <= rx_data;
        end
      end else begin : g_rest
        always_ff @(posedge cpu_clock or posedge cpu_rst) begin
          if (cpu_rst) sync_reg[gi] <= 1'b1;
          else         sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rxs = sync_reg[1];

  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) rxs_prev_reg <= 1'b1;
    else         rxs_prev_reg <= rxs;
  end

  // Receiver state machine
  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_reg;
  logic [7:0]  shift_reg;
  logic        cnt_zero;

  assign cnt_zero = (cnt_reg == 16'd0);

  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 16'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rxs_prev_reg && !rxs) begin
            state_reg <= ST_START;
            cnt_reg   <= HALF_M1;
          end
        end
        ST_START: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (!rxs) begin
            state_reg <= ST_DATA;
            cnt_reg   <= FULL_M1;
            bit_reg   <= 3'd0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            shift_reg <= {rxs, shift_reg[7:1]};
            cnt_reg   <= FULL_M1;
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!cnt_zero) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            cnt_reg   <= FULL_M1;
            state_reg <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!cnt_zero) cnt_reg <= cnt_reg - 16'd1;
          else           state_reg <= rxs ? ST_IDLE : ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (rxs) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Events decided on the sample cycle itself so the FIFO sees them on that edge.
  logic push_fire;
  logic frame_fire;
  assign push_fire  = (state_reg == ST_STOP) && cnt_zero && rxs;
  assign frame_fire = (state_reg == ST_STOP) && cnt_zero && !rxs;

  // FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          ov_fire;

  assign full    = (count_reg == CNT_FULL);
  assign pop     = rd_en && (count_reg != '0);
  assign do_push = push_fire && (!full || pop);
  assign ov_fire = push_fire && full && !pop;

  always_ff @(posedge cpu_clock) begin
    if (do_push) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Fall-through head needs an asynchronous read; an empty FIFO presents zero.
  assign rd_valid  = (count_reg != '0);
  assign fifo_full = full;
  assign rd_data   = rd_valid ? mem[rd_ptr_reg] : 8'h00;

  // Sticky flags: a set event in the clear cycle takes priority.
  logic frame_err_reg;
  logic overflow_reg;

  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      frame_err_reg <= frame_fire | (frame_err_reg & ~clr);
      overflow_reg  <= ov_fire    | (overflow_reg  & ~clr);
    end
  end

  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

`ifdef UART_RX_PARITY_EN
  logic parity_fire;
  logic parity_err_reg;
  assign parity_fire = (state_reg == ST_PARITY) && cnt_zero && ((^shift_reg) != rxs);

  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) parity_err_reg <= 1'b0;
    else         parity_err_reg <= parity_fire | (parity_err_reg & ~clr);
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
